// File: rtl/nios_debug_cmd_sync.sv
// nios_debug_cmd_sync: system-clock-side command front end for the Nios II
// JTAG debug module. It resynchronises the TCK-domain update-IR/update-DR
// toggles, captures the instruction and the shift register, and issues a
// one-cycle action/no-action strobe per instruction.
// Optional feature macro: NIOS_DBG_CMD_ACK_EN. When it is defined, a WAIT
// state holds cmd_busy high until cmd_ack arrives.
module nios_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 35
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vs_uir_tgl,
    input  logic                   vs_udr_tgl,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DATA_W-1:0]      sr,
    input  logic                   cmd_ack,
    output logic [DATA_W-1:0]      jdo,
    output logic [IR_W-1:0]        ir_q,
    output logic [(2**IR_W)-1:0]   take_action,
    output logic [(2**IR_W)-1:0]   take_no_action,
    output logic                   cmd_busy,
    output logic [7:0]             overrun_cnt
);

    localparam int N_INSTR = 2**IR_W;
    // Edges stay suppressed until the synchroniser and previous-value
    // register hold real samples.
    localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

`ifdef NIOS_DBG_CMD_ACK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE} state_e;
    // cmd_ack has no effect without the acknowledge handshake.
    logic unused_ack;
    assign unused_ack = cmd_ack;
`endif

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_prev_q, udr_prev_q;
    logic                   uir_evt_q, udr_evt_q;
    logic [2:0]             warm_cnt_q;
    logic                   warm_done;

    logic [DATA_W-1:0]      jdo_q, jdo_d;
    logic [IR_W-1:0]        ir_lat_q, ir_lat_d;
    logic [N_INSTR-1:0]     act_q, act_d, noact_q, noact_d;
    logic [7:0]             overrun_q, overrun_d;
    logic                   accept;

    assign warm_done = (warm_cnt_q == 3'd0);

    // Synchronise the toggles, detect edges and register them as one-cycle events.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_prev_q <= 1'b0;
            udr_prev_q <= 1'b0;
            uir_evt_q  <= 1'b0;
            udr_evt_q  <= 1'b0;
            warm_cnt_q <= WARM_LOAD;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
            uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
            udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
            uir_evt_q  <= warm_done && (uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q);
            udr_evt_q  <= warm_done && (udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q);
            if (!warm_done) begin
                warm_cnt_q <= warm_cnt_q - 3'd1;
            end
        end
    end

    // Next state, capture, strobe decode and overrun accounting.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        jdo_d     = jdo_q;
        ir_lat_d  = ir_lat_q;
        act_d     = '0;
        noact_d   = '0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (udr_evt_q) begin
                    state_d = ST_ISSUE;
                    accept  = 1'b1;
                end
            end
`ifdef NIOS_DBG_CMD_ACK_EN
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cmd_ack) begin
                    state_d = ST_IDLE;
                end
            end
`else
            ST_ISSUE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        // A simultaneous uir event updates the instruction before the command uses it.
        if (uir_evt_q) begin
            ir_lat_d = ir_in;
        end

        if (accept) begin
            jdo_d = sr;
            if (sr[ACT_BIT]) begin
                act_d[ir_lat_d] = 1'b1;
            end else begin
                noact_d[ir_lat_d] = 1'b1;
            end
        end

        if (udr_evt_q && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // State and output registers; strobes are registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            jdo_q     <= '0;
            ir_lat_q  <= '0;
            act_q     <= '0;
            noact_q   <= '0;
            overrun_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            jdo_q     <= jdo_d;
            ir_lat_q  <= ir_lat_d;
            act_q     <= act_d;
            noact_q   <= noact_d;
            overrun_q <= overrun_d;
        end
    end

    assign jdo            = jdo_q;
    assign ir_q           = ir_lat_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign cmd_busy       = (state_q != ST_IDLE);
    assign overrun_cnt    = overrun_q;

endmodule
